// File: rtl/axis_switch.sv
// AXI4-Stream crossbar: S_COUNT inputs routed by tdest to M_COUNT outputs with per-output round-robin.
// Define AXIS_SWITCH_SKID_EN to build each output stage as a 2-entry skid buffer with registered ready.
module axis_switch #(
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 1,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = $clog2(M_COUNT+1),
  parameter int USER_WIDTH = 1,
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_BASE = '0,
  parameter logic [M_COUNT*DEST_WIDTH-1:0] M_TOP  = '1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser
);

  localparam int SEL_W    = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int LAST_POS = ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int PL_W     = DATA_WIDTH + KEEP_WIDTH + 1 + LAST_POS;

  function automatic logic in_range(input logic [DEST_WIDTH-1:0] d,
                                    input logic [DEST_WIDTH-1:0] lo,
                                    input logic [DEST_WIDTH-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  logic [PL_W-1:0]    s_pl      [S_COUNT];
  logic [M_COUNT-1:0] route     [S_COUNT];
  logic [S_COUNT-1:0] no_match;
  logic [S_COUNT-1:0] busy;
  logic [S_COUNT-1:0] drop_act;

  logic [SEL_W-1:0]   grant_sel [M_COUNT];
  logic [SEL_W-1:0]   rr_ptr    [M_COUNT];
  logic [SEL_W-1:0]   win       [M_COUNT];
  logic [PL_W-1:0]    in_pl     [M_COUNT];
  logic [M_COUNT-1:0] grant_vld;
  logic [M_COUNT-1:0] any_req;
  logic [M_COUNT-1:0] stage_rdy;
  logic [M_COUNT-1:0] in_vld;
  logic [M_COUNT-1:0] in_acc;
  logic [M_COUNT-1:0] in_last;

  // Beat payload packed as {tdata, tkeep, tlast, tid, tdest, tuser}, all sliced with the same port index.
  for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_in
    assign s_pl[gi] = {s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH],
                       s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH],
                       s_axis_tlast[gi],
                       s_axis_tid[gi*ID_WIDTH +: ID_WIDTH],
                       s_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH],
                       s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH]};
  end

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      route[i]    = '0;
      no_match[i] = 1'b1;
      for (int j = 0; j < M_COUNT; j++) begin
        if (no_match[i] && in_range(s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
                                    M_BASE[j*DEST_WIDTH +: DEST_WIDTH],
                                    M_TOP[j*DEST_WIDTH +: DEST_WIDTH])) begin
          route[i][j] = 1'b1;
          no_match[i] = 1'b0;
        end
      end
    end
  end

  // An input holding any grant is mid-frame; its later tdest values must not raise new requests.
  always_comb begin
    busy = '0;
    for (int j = 0; j < M_COUNT; j++)
      for (int i = 0; i < S_COUNT; i++)
        if (grant_vld[j] && grant_sel[j] == SEL_W'(i)) busy[i] = 1'b1;
  end

  always_comb begin
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int j = 0; j < M_COUNT; j++) begin
      any_req[j] = 1'b0;
      win[j]     = '0;
      for (int off = 0; off < S_COUNT; off++) begin
        idx = SEL_W'((int'(rr_ptr[j]) + off) % S_COUNT);
        if (!any_req[j] && s_axis_tvalid[idx] && !busy[idx] && !drop_act[idx] && route[idx][j]) begin
          any_req[j] = 1'b1;
          win[j]     = idx;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < M_COUNT; j++) begin
      in_pl[j]   = s_pl[grant_sel[j]];
      in_vld[j]  = grant_vld[j] && s_axis_tvalid[grant_sel[j]];
      in_acc[j]  = in_vld[j] && stage_rdy[j];
      in_last[j] = in_pl[j][LAST_POS];
    end
  end

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      s_axis_tready[i] = drop_act[i] || (s_axis_tvalid[i] && !busy[i] && no_match[i]);
      for (int j = 0; j < M_COUNT; j++)
        if (grant_vld[j] && grant_sel[j] == SEL_W'(i) && stage_rdy[j]) s_axis_tready[i] = 1'b1;
    end
  end

  // Arbitration stage: grant registered at the edge, released by the accepted tlast beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_vld <= '0;
      for (int j = 0; j < M_COUNT; j++) begin
        grant_sel[j] <= '0;
        rr_ptr[j]    <= '0;
      end
    end else begin
      for (int j = 0; j < M_COUNT; j++) begin
        if (!grant_vld[j]) begin
          if (any_req[j]) begin
            grant_vld[j] <= 1'b1;
            grant_sel[j] <= win[j];
            rr_ptr[j]    <= SEL_W'((int'(win[j]) + 1) % S_COUNT);
          end
        end else if (in_acc[j] && in_last[j]) begin
          grant_vld[j] <= 1'b0;
        end
      end
    end
  end

  // Unroutable frames are swallowed beat by beat until their tlast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_act <= '0;
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (drop_act[i]) begin
          if (s_axis_tvalid[i] && s_axis_tlast[i]) drop_act[i] <= 1'b0;
        end else if (s_axis_tvalid[i] && !busy[i] && no_match[i] && !s_axis_tlast[i]) begin
          drop_act[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar gj = 0; gj < M_COUNT; gj++) begin : g_out
    logic [PL_W-1:0] out_pl;
    logic            out_vld;

`ifdef AXIS_SWITCH_SKID_EN
    logic [PL_W-1:0] skid_pl;
    logic            skid_vld;
    logic            rdy_r;
    logic            pop;
    logic            nxt_out_vld;
    logic            nxt_skid_vld;

    assign stage_rdy[gj] = rdy_r;

    always_comb begin
      pop          = out_vld && m_axis_tready[gj];
      nxt_out_vld  = out_vld;
      nxt_skid_vld = skid_vld;
      if (!out_vld) begin
        nxt_out_vld = in_acc[gj];
      end else if (pop) begin
        if (skid_vld) nxt_skid_vld = in_acc[gj];
        else          nxt_out_vld  = in_acc[gj];
      end else if (in_acc[gj]) begin
        nxt_skid_vld = 1'b1;
      end
    end

    // Output stage: head register plus skid entry; ready only drops once both are full.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
        rdy_r    <= 1'b1;
        out_pl   <= '0;
        skid_pl  <= '0;
      end else begin
        out_vld  <= nxt_out_vld;
        skid_vld <= nxt_skid_vld;
        rdy_r    <= !(nxt_out_vld && nxt_skid_vld);
        if (!out_vld || (pop && !skid_vld)) begin
          if (in_acc[gj]) out_pl <= in_pl[gj];
        end else if (pop) begin
          out_pl <= skid_pl;
          if (in_acc[gj]) skid_pl <= in_pl[gj];
        end else if (in_acc[gj]) begin
          skid_pl <= in_pl[gj];
        end
      end
    end
`else
    assign stage_rdy[gj] = m_axis_tready[gj] || !out_vld;

    // Output stage: single register slice, refilled whenever the current beat leaves.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_vld <= 1'b0;
        out_pl  <= '0;
      end else if (stage_rdy[gj]) begin
        out_vld <= in_acc[gj];
        if (in_acc[gj]) out_pl <= in_pl[gj];
      end
    end
`endif

    assign m_axis_tvalid[gj]                          = out_vld;
    assign m_axis_tuser[gj*USER_WIDTH +: USER_WIDTH]  = out_pl[0 +: USER_WIDTH];
    assign m_axis_tdest[gj*DEST_WIDTH +: DEST_WIDTH]  = out_pl[USER_WIDTH +: DEST_WIDTH];
    assign m_axis_tid[gj*ID_WIDTH +: ID_WIDTH]        = out_pl[USER_WIDTH+DEST_WIDTH +: ID_WIDTH];
    assign m_axis_tlast[gj]                           = out_pl[LAST_POS];
    assign m_axis_tkeep[gj*KEEP_WIDTH +: KEEP_WIDTH]  = out_pl[LAST_POS+1 +: KEEP_WIDTH];
    assign m_axis_tdata[gj*DATA_WIDTH +: DATA_WIDTH]  = out_pl[LAST_POS+1+KEEP_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_axis_switch.sv
// Directed bench for axis_switch (default parameters): vector table plus backpressure and async-reset sequences.
module tb_axis_switch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = 4'hf;
  logic [3:0]  s_tvalid = '0;
  logic [3:0]  s_tready;
  logic [3:0]  s_tlast = '0;
  logic [31:0] s_tid = '0;
  logic [3:0]  s_tdest = '0;
  logic [3:0]  s_tuser = '0;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [7:0]  m_tid;
  logic [0:0]  m_tdest;
  logic [0:0]  m_tuser;

  axis_switch dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [31:0] id;
    logic [3:0]  last;
    logic        mrdy;
    logic [3:0]  exp_srdy;
    logic        exp_mvld;
    logic [7:0]  exp_data;
    logic [7:0]  exp_id;
    logic        exp_last;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] vld, input logic [31:0] data, input logic [31:0] id,
                     input logic [3:0] last, input logic [3:0] srdy, input logic mvld,
                     input logic [7:0] d, input logic [7:0] i, input logic l);
    vec_t v;
    v = '{vld, data, id, last, 1'b1, srdy, mvld, d, i, l};
    vecs.push_back(v);
  endtask

  initial begin
    int beat, got;
    logic [7:0] prev_d;
    logic prev_stall;

    // Reset state, then idle after release.
    #12;
    chk("rst_mvld", {31'b0, m_tvalid}, 32'd0);
    chk("rst_srdy", {28'b0, s_tready}, 32'd0);
    chk("rst_mdata", {24'b0, m_tdata}, 32'd0);
    chk("rst_mid", {24'b0, m_tid}, 32'd0);
    chk("rst_mlast", {31'b0, m_tlast}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      chk("idle_mvld", {31'b0, m_tvalid}, 32'd0);
      chk("idle_srdy", {28'b0, s_tready}, 32'd0);
    end

    // Single-beat frames from all four inputs.
    add(4'b1111, 32'habcd1234, 32'h01020304, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b1111, 32'habcd1234, 32'h01020304, 4'hf, 4'b0001, 1, 8'h34, 8'h04, 1);
    add(4'b1110, 32'habcd1234, 32'h01020304, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b1110, 32'habcd1234, 32'h01020304, 4'hf, 4'b0010, 1, 8'h12, 8'h03, 1);
    add(4'b1100, 32'habcd1234, 32'h01020304, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b1100, 32'habcd1234, 32'h01020304, 4'hf, 4'b0100, 1, 8'hcd, 8'h02, 1);
    add(4'b1000, 32'habcd1234, 32'h01020304, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b1000, 32'habcd1234, 32'h01020304, 4'hf, 4'b1000, 1, 8'hab, 8'h01, 1);
    add(4'b0000, 32'habcd1234, 32'h01020304, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
    // Round-robin between inputs 0 and 3 sending continuously.
    for (int r = 0; r < 2; r++) begin
      add(4'b1001, 32'h33000030, 32'h0d00000a, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
      add(4'b1001, 32'h33000030, 32'h0d00000a, 4'hf, 4'b0001, 1, 8'h30, 8'h0a, 1);
      add(4'b1001, 32'h33000030, 32'h0d00000a, 4'hf, 4'b0000, 0, 8'h00, 8'h00, 0);
      add(4'b1001, 32'h33000030, 32'h0d00000a, 4'hf, 4'b1000, 1, 8'h33, 8'h0d, 1);
    end
    add(4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 0, 8'h00, 8'h00, 0);
    // Three-beat frame on input 0 blocks input 1 until its tlast.
    add(4'b0011, 32'h00002010, 32'h0000b1a0, 4'b0010, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b0011, 32'h00002010, 32'h0000b1a0, 4'b0010, 4'b0001, 1, 8'h10, 8'ha0, 0);
    add(4'b0011, 32'h00002011, 32'h0000b1a0, 4'b0010, 4'b0001, 1, 8'h11, 8'ha0, 0);
    add(4'b0011, 32'h00002012, 32'h0000b1a0, 4'b0011, 4'b0001, 1, 8'h12, 8'ha0, 1);
    add(4'b0010, 32'h00002012, 32'h0000b1a0, 4'b0011, 4'b0000, 0, 8'h00, 8'h00, 0);
    add(4'b0010, 32'h00002012, 32'h0000b1a0, 4'b0011, 4'b0010, 1, 8'h20, 8'hb1, 1);
    add(4'b0000, 32'h0, 32'h0, 4'h0, 4'b0000, 0, 8'h00, 8'h00, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      s_tvalid = vecs[k].vld;
      s_tdata  = vecs[k].data;
      s_tid    = vecs[k].id;
      s_tlast  = vecs[k].last;
      m_tready = vecs[k].mrdy;
      #1;
      chk($sformatf("v%0d_srdy", k), {28'b0, s_tready}, {28'b0, vecs[k].exp_srdy});
      @(posedge clk); #2;
      chk($sformatf("v%0d_mvld", k), {31'b0, m_tvalid}, {31'b0, vecs[k].exp_mvld});
      if (vecs[k].exp_mvld) begin
        chk($sformatf("v%0d_mdata", k), {24'b0, m_tdata}, {24'b0, vecs[k].exp_data});
        chk($sformatf("v%0d_mid", k), {24'b0, m_tid}, {24'b0, vecs[k].exp_id});
        chk($sformatf("v%0d_mlast", k), {31'b0, m_tlast}, {31'b0, vecs[k].exp_last});
      end
    end

    // Five-beat frame on input 0 with the output stalled for three cycles mid-frame.
    beat = 0; got = 0; prev_d = '0; prev_stall = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      s_tvalid = (beat < 5) ? 4'b0001 : 4'b0000;
      s_tdata  = 32'(8'h40 + beat);
      s_tlast  = (beat == 4) ? 4'b0001 : 4'b0000;
      s_tid    = 32'h000000c0;
      m_tready = !(c >= 3 && c <= 5);
      #3;
      if (prev_stall) begin
        chk("stall_mvld", {31'b0, m_tvalid}, 32'd1);
        chk("stall_mdata", {24'b0, m_tdata}, {24'b0, prev_d});
      end
      if (m_tvalid && m_tready) begin
        chk("bp_mdata", {24'b0, m_tdata}, 32'(8'h40 + got));
        chk("bp_mlast", {31'b0, m_tlast}, {31'b0, got == 4});
        got++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      if (s_tvalid[0] && s_tready[0]) beat++;
      @(posedge clk); #2;
    end
    chk("bp_count", got, 32'd5);
    s_tvalid = '0;
    m_tready = 1'b1;
    @(posedge clk); #2;

    // Async reset in the middle of an input 1 frame.
    s_tvalid = 4'b0010; s_tdata = 32'h00005500; s_tlast = 4'b0000; s_tid = '0;
    m_tready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_mvld", {31'b0, m_tvalid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_mvld", {31'b0, m_tvalid}, 32'd0);
    chk("async_rst_srdy", {28'b0, s_tready}, 32'd0);
    chk("async_rst_mdata", {24'b0, m_tdata}, 32'd0);
    s_tvalid = 4'b0111; s_tdata = 32'h00625150; s_tlast = 4'b0111; m_tready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("post_rst_srdy0", {28'b0, s_tready}, 32'd0);
    @(posedge clk); #3;
    chk("post_rst_rr_srdy", {28'b0, s_tready}, 32'b0001);
    @(posedge clk); #2;
    chk("post_rst_mvld", {31'b0, m_tvalid}, 32'd1);
    chk("post_rst_mdata", {24'b0, m_tdata}, 32'h50);
    s_tvalid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_switch.md
Name: axis_switch

Overview:
- Parameterised AXI4-Stream crossbar: S_COUNT slave inputs, M_COUNT master outputs.
- Each input frame is routed by its tdest to one output. Each output arbitrates round-robin among the inputs requesting it.
- The granting input keeps the output until its tlast beat. Sits between stream producers and consumers in the datapath fabric.

Parameters:
S_COUNT, 4, number of input ports
M_COUNT, 1, number of output ports
DATA_WIDTH, 8, tdata width per port
KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port
ID_WIDTH, 8, tid width per port
DEST_WIDTH, $clog2(M_COUNT+1), tdest width per port
USER_WIDTH, 1, tuser width per port
M_BASE, {M_COUNT{DEST_WIDTH'd0}}, packed lowest tdest accepted by each output
M_TOP, {M_COUNT{all-ones}}, packed highest tdest accepted by each output (inclusive)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  byte enables
s_axis_tvalid  in  S_COUNT  beat valid
s_axis_tready  out  S_COUNT  beat accepted
s_axis_tlast  in  S_COUNT  end of frame
s_axis_tid  in  S_COUNT*ID_WIDTH  stream id
s_axis_tdest  in  S_COUNT*DEST_WIDTH  routing destination
s_axis_tuser  in  S_COUNT*USER_WIDTH  sideband
m_axis_tdata  out  M_COUNT*DATA_WIDTH  output data
m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  output byte enables
m_axis_tvalid  out  M_COUNT  output valid
m_axis_tready  in  M_COUNT  downstream ready
m_axis_tlast  out  M_COUNT  output end of frame
m_axis_tid  out  M_COUNT*ID_WIDTH  output id
m_axis_tdest  out  M_COUNT*DEST_WIDTH  output dest (passed through unchanged)
m_axis_tuser  out  M_COUNT*USER_WIDTH  output user

Behaviour:
- Reset (rst=0, async): all grants cleared; round-robin pointers = 0; m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tid/tdest/tuser=0; s_axis_tready=0.
- All per-port fields use the same slice indexing: port i occupies [i*W +: W] for every signal. tdata, tkeep, tid, tdest and tuser must all use the same index i.
- Routing: input i requests output j when tvalid=1 and M_BASE[j] <= tdest <= M_TOP[j]. If ranges overlap, the lowest j wins. A frame matching no output is consumed (tready=1) and discarded.
- Destination is sampled on the first beat of a frame and held for all beats until tlast.
- Arbitration per output, only when that output has no grant:
  - Round-robin, starting search at pointer p. After reset p=0, so the LSB input has highest priority.
  - Granting input k registers grant at the clock edge and sets p=(k+1) mod S_COUNT.
- Grant holds until the beat with tlast=1 is transferred on the input side; it releases at that edge. Next arbitration occurs the following cycle, so one idle cycle separates frames on the same output.
- s_axis_tready[i] = grant active for i && output stage can accept. Non-granted inputs see tready=0.
- Output stage: one register slice per output. Latency is 1 cycle from input handshake to m_axis_tvalid. Full throughput (1 beat/cycle) while m_axis_tready=1.
- Backpressure: data is held stable while m_axis_tvalid=1 and m_axis_tready=0. No beat is lost or duplicated.
- An input dropping tvalid mid-frame keeps its grant. Other inputs wait.

Optional Feature:
- AXIS_SWITCH_SKID_EN defined: output stage is a 2-entry skid buffer. Readiness toward the inputs is registered, with no combinational path from m_axis_tready to s_axis_tready.
- Not defined: single register. Ready = m_axis_tready || !m_axis_tvalid (combinational path).
- Latency and throughput are identical in both builds.

Test Plan:
- Reset, then rst=1 with no valids -> m_axis_tvalid=0 and all s_axis_tready=0 for 4 cycles.
- Single-beat frames, all 4 inputs valid, tdata=32'habcd1234, tid=32'h01020304, tlast=4'b1111, m_axis_tready=1:
  - Outputs appear in order 0x34/id 0x04, 0x12/id 0x03, 0xcd/id 0x02, 0xab/id 0x01, each with tlast=1.
  - Each beat is separated by one idle cycle.
- Input 0 sends a 3-beat frame (0x10, 0x11, 0x12, tlast on last) while input 1 is valid -> input 1 gets s_axis_tready=0 until input 0's tlast transfers. Input 1's frame follows after the idle cycle.
- m_axis_tready=0 for 3 cycles mid-frame -> m_axis_tdata stays constant. All beats are delivered in order after ready returns.
- Round-robin fairness: input 0 and input 3 send back-to-back frames continuously -> grants alternate 0, 3, 0, 3.
- Assert rst=0 asynchronously mid-frame -> m_axis_tvalid=0 immediately. After release, the next arbitration starts from input 0.
